regfile_mp: RTL
===============

# regfile_mp

Multi-port general-purpose register file for the next CPU core generation. It generalises the single-write/dual-read register set to NUM_RD read ports and NUM_WR write ports, and adds write-to-read bypass and a per-register pending scoreboard for multi-cycle producers such as loads. It sits between decode (reads, reservations) and writeback (writes), and is frozen by the pipeline stall.

## Interface
- REGISTER_DEPTH, 32, number of registers; must equal 2**ADDR_WIDTH.
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register width.
- NUM_RD, 2, read ports (1..4).
- NUM_WR, 2, write ports (1..2).
- ZERO_REG, 1, if 1 register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1, if 1 a same-cycle write is forwarded to matching reads.
- clk  in  1  clock.
- reset_b  in  1  reset, asynchronous, active-low.
- stall  in  1  blocks all writes and reservations this cycle.
- rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_RD*DATA_WIDTH  read data, combinational.
- rd_busy  out  NUM_RD  addressed register has an outstanding reservation.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*ADDR_WIDTH  write addresses.
- wr_data  in  NUM_WR*DATA_WIDTH  write data.
- rsv_en  in  1  mark rsv_addr pending (issue of a multi-cycle producer).
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- any_busy  out  1  OR of all pending bits, registered view.

## Operation
- Effective write w: wr_en[w] & ~stall & ~(ZERO_REG & wr_addr==0).
- Commit: on posedge clk, each effective write updates memory[wr_addr[w]]. If two ports target the same address, the higher port index wins.
- Read p: if ZERO_REG and the address is 0, return 0. Else if BYPASS and an effective write matches, return that write's data (highest matching index). Else return memory.
- With stall high, bypass never fires; reads return committed state.
- Scoreboard: one pending bit per register.
  - Effective write clears the bit.
  - rsv_en & ~stall sets the bit (ignored for reg 0 when ZERO_REG).
  - Set and clear on the same register in the same cycle: set wins, because the new producer is the youngest.
- rd_busy[p] = pending[rd_addr p] & ~(BYPASS & an effective write to that address this cycle). Forwarded data is never reported busy.
- any_busy is a combinational OR of the pending vector (the vector itself is registered).

## Timing
- Write latency 1 cycle to storage. With BYPASS, the read port sees write data in the same cycle (0-cycle forward). Without BYPASS, it sees the data the following cycle.
- Reservation is visible on rd_busy the cycle after rsv_en.
- Reset (asynchronous, any time, including mid-write): all registers 0, all pending bits 0. rd_data reflects 0 for every address, and rd_busy = 0, any_busy = 0, immediately.
- The first effective write is the first posedge clk with reset_b high.
- No handshake; the caller must hold stall for as long as the pipeline is frozen.

## Structure
- Shared package regfile_pkg: default width/depth/port-count localparams, ZERO_ADDR constant, and port slice helper functions.
- One sub-module, regfile_scoreboard: pending vector, set/clear priority, any_busy, and the rd_busy lookup.
- Storage, write arbitration and the bypass mux stay in regfile_mp.

## Test plan
- Reset then read all 32 addresses on both ports -> rd_data = 0, rd_busy = 0, any_busy = 0.
- wr_en=01, wr_addr0=5, wr_data0=0xDEADBEEF, rd_addr0=5, same cycle -> rd_data0 = 0xDEADBEEF that cycle (BYPASS=1). With BYPASS=0: old value that cycle, 0xDEADBEEF the next.
- Both ports write reg 7 (0x11, 0x22) -> reads 0x22 next cycle. A write to reg 0 of 0xFFFFFFFF -> reg 0 still reads 0.
- rsv_en, rsv_addr=9 -> rd_busy for reg 9 = 1 next cycle, any_busy = 1. Then write reg 9 = 0x5A -> same-cycle rd_busy = 0, rd_data = 0x5A; pending cleared after the edge.
- Same cycle rsv_en reg 3 and write reg 3 -> pending stays 1, data updated.
- stall=1 with wr_en and rsv_en active -> no storage or pending change, no bypass.
- Assert reset_b mid-cycle after writes to regs 1..4 -> all reads 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and port-slicing helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;
  localparam int ZERO_ADDR  = 0;

  // Low bit of port `port` inside a flattened bus of `width`-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for multi-cycle producers, plus the busy lookup
// seen by each read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int REGISTER_DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_W,
  parameter int NUM_RD         = DEF_NUM_RD,
  parameter int ZERO_REG       = 1
) (
  input  logic                         clk,
  input  logic                         reset_b,
  input  logic                         stall,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  input  logic [REGISTER_DEPTH-1:0]    clr_vec,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_RD-1:0]            fwd_hit,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic                         any_busy
);

  logic [REGISTER_DEPTH-1:0] pend_q;
  logic [REGISTER_DEPTH-1:0] pend_d;
  logic                      rsv_eff;

  // NOTE: every variable written here gets a full default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rsv_eff = rsv_en && !stall;
    if (ZERO_REG != 0 && rsv_addr == ADDR_WIDTH'(ZERO_ADDR)) rsv_eff = 1'b0;
    pend_d = pend_q & ~clr_vec;
    // Set after clear: the new reservation belongs to the youngest producer.
    if (rsv_eff) pend_d[rsv_addr] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  // Forwarded data is complete, so a bypassed read never reports busy.
  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_busy[p] = pend_q[rd_addr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH]] & ~fwd_hit[p];
    end
  end

  assign any_busy = |pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, write arbitration (higher port wins),
// same-cycle write-to-read bypass and the pending scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int REGISTER_DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_W,
  parameter int DATA_WIDTH     = DEF_DATA_W,
  parameter int NUM_RD         = DEF_NUM_RD,
  parameter int NUM_WR         = DEF_NUM_WR,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input  logic                         clk,
  input  logic                         reset_b,
  input  logic                         stall,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic                         any_busy
);

  logic [DATA_WIDTH-1:0]     mem_q [REGISTER_DEPTH];
  logic [DATA_WIDTH-1:0]     mem_d [REGISTER_DEPTH];
  logic [NUM_WR-1:0]         wr_eff;
  logic [REGISTER_DEPTH-1:0] clr_vec;
  logic [NUM_RD-1:0]         fwd_hit;

  // Ports are walked in ascending order so the highest index lands last.
  always_comb begin : write_arb
    wr_eff  = '0;
    clr_vec = '0;
    for (int i = 0; i < REGISTER_DEPTH; i++) mem_d[i] = mem_q[i];
    for (int w = 0; w < NUM_WR; w++) begin
      wr_eff[w] = wr_en[w] && !stall &&
                  !(ZERO_REG != 0 &&
                    wr_addr[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(ZERO_ADDR));
      if (wr_eff[w]) begin
        mem_d[wr_addr[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH]]   =
          wr_data[slice_lo(w, DATA_WIDTH) +: DATA_WIDTH];
        clr_vec[wr_addr[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
      end
    end
  end

  // NOTE: the storage array is reset like ordinary state because every address
  // must read 0 the instant reset_b falls.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < REGISTER_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < REGISTER_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin : read_mux
    rd_data = '0;
    fwd_hit = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] =
        mem_q[rd_addr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_eff[w] && wr_addr[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH] ==
                           rd_addr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH]) begin
            rd_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] =
              wr_data[slice_lo(w, DATA_WIDTH) +: DATA_WIDTH];
            fwd_hit[p] = 1'b1;
          end
        end
      end
      if (ZERO_REG != 0 &&
          rd_addr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(ZERO_ADDR)) begin
        rd_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = '0;
      end
    end
  end

  regfile_scoreboard #(
    .REGISTER_DEPTH (REGISTER_DEPTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .NUM_RD         (NUM_RD),
    .ZERO_REG       (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset_b  (reset_b),
    .stall    (stall),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_vec  (clr_vec),
    .rd_addr  (rd_addr),
    .fwd_hit  (fwd_hit),
    .rd_busy  (rd_busy),
    .any_busy (any_busy)
  );

endmodule
